// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline sequencer: load-use/branch hazards, imem/dmem stalls, wrong-path kill
// Mealy outputs over a three-state fetch tracker plus saturating perf counters.
module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             id_uses_rt_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             branch_taken_i,
  input  logic             imem_stall_i,
  input  logic             dmem_stall_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_flush_o,
  output logic             pipe_hold_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] redirect_cnt_o
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    IWAIT      = 2'd1,
    IWAIT_KILL = 2'd2
  } state_t;

  state_t state, state_next;
  logic   lu;
  logic   redirect_inc;

  assign lu = ex_memread_i && (ex_rd_i != 5'd0) &&
              ((ex_rd_i == id_rs_i) || (id_uses_rt_i && (ex_rd_i == id_rt_i)));

  always_comb begin
    pc_write_o   = 1'b0;
    ifid_write_o = 1'b0;
    ifid_flush_o = 1'b0;
    idex_flush_o = 1'b0;
    pipe_hold_o  = 1'b0;
    redirect_inc = 1'b0;
    state_next   = state;
    if (rst_i) begin
      ifid_flush_o = 1'b1;
      idex_flush_o = 1'b1;
    end else if (dmem_stall_i) begin
      pipe_hold_o = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (lu) begin
            idex_flush_o = 1'b1;
          end else if (imem_stall_i) begin
            // The fetch in flight keeps its latched address; a redirect here
            // makes its eventual return wrong-path.
            ifid_flush_o = 1'b1;
            pc_write_o   = branch_taken_i;
            redirect_inc = branch_taken_i;
            state_next   = branch_taken_i ? IWAIT_KILL : IWAIT;
          end else if (branch_taken_i) begin
            pc_write_o   = 1'b1;
            ifid_flush_o = 1'b1;
            redirect_inc = 1'b1;
          end else begin
            pc_write_o   = 1'b1;
            ifid_write_o = 1'b1;
          end
        end
        IWAIT: begin
          if (imem_stall_i) begin
            ifid_flush_o = 1'b1;
          end else begin
            pc_write_o   = 1'b1;
            ifid_write_o = 1'b1;
            state_next   = RUN;
          end
        end
        IWAIT_KILL: begin
          ifid_flush_o = 1'b1;
          if (!imem_stall_i) begin
            state_next = RUN;
          end
        end
        default: begin
          state_next = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= RUN;
      stall_cnt_o    <= '0;
      redirect_cnt_o <= '0;
    end else begin
      state <= state_next;
      if (!pc_write_o && (stall_cnt_o != '1)) begin
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      end
      if (redirect_inc && (redirect_cnt_o != '1)) begin
        redirect_cnt_o <= redirect_cnt_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
// Vector table, hand sequences and a randomized run against a behavioural scoreboard.
module tb_hazard_ctrl;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       id_rs, id_rt, ex_rd;
  logic             id_uses_rt, ex_memread, branch_taken, imem_stall, dmem_stall;
  logic             pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold;
  logic [CNT_W-1:0] stall_cnt, redirect_cnt;

  int checks = 0;
  int errors = 0;
  logic sb_en = 1'b0;

  // Reference state: waiting on a fetch, and whether that fetch is wrong-path.
  logic m_wait = 1'b0;
  logic m_kill = 1'b0;
  int   m_stall = 0;
  int   m_redir = 0;

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst),
    .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rt_i(id_uses_rt),
    .ex_memread_i(ex_memread), .ex_rd_i(ex_rd),
    .branch_taken_i(branch_taken), .imem_stall_i(imem_stall), .dmem_stall_i(dmem_stall),
    .pc_write_o(pc_write), .ifid_write_o(ifid_write), .ifid_flush_o(ifid_flush),
    .idex_flush_o(idex_flush), .pipe_hold_o(pipe_hold),
    .stall_cnt_o(stall_cnt), .redirect_cnt_o(redirect_cnt)
  );

  always #5 clk = ~clk;

  // {pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold}
  function automatic logic [4:0] model_out();
    logic hz;
    hz = ex_memread && (ex_rd != 0) && (ex_rd == id_rs || (id_uses_rt && ex_rd == id_rt));
    if (rst)             return 5'b00110;
    if (dmem_stall)      return 5'b00001;
    if (m_wait) begin
      if (imem_stall || m_kill) return 5'b00100;
      return 5'b11000;
    end
    if (hz)              return 5'b00010;
    if (imem_stall)      return {branch_taken, 1'b0, 1'b1, 2'b00};
    if (branch_taken)    return 5'b10100;
    return 5'b11000;
  endfunction

  always @(posedge clk) begin : model_update
    logic [4:0] o;
    logic hz;
    o  = model_out();
    hz = ex_memread && (ex_rd != 0) && (ex_rd == id_rs || (id_uses_rt && ex_rd == id_rt));
    if (rst) begin
      m_wait = 1'b0; m_kill = 1'b0; m_stall = 0; m_redir = 0;
    end else begin
      if (!o[4] && m_stall < CNT_MAX) m_stall++;
      if (!dmem_stall) begin
        if (m_wait) begin
          if (!imem_stall) begin m_wait = 1'b0; m_kill = 1'b0; end
        end else if (!hz) begin
          if (branch_taken && m_redir < CNT_MAX) m_redir++;
          if (imem_stall) begin m_wait = 1'b1; m_kill = branch_taken; end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (sb_en) begin
      logic [4:0] e, a;
      e = model_out();
      a = {pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL sb_outputs t=%0t got %b want %b", $time, a, e);
      end
      checks++;
      if (int'(stall_cnt) != m_stall || int'(redirect_cnt) != m_redir) begin
        errors++;
        $display("FAIL sb_counters t=%0t got stall=%0d redir=%0d want stall=%0d redir=%0d",
                 $time, stall_cnt, redirect_cnt, m_stall, m_redir);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic [4:0] exp);
    chk(name, int'({pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold}), int'(exp));
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk); #1;
  endtask

  task automatic idle();
    rst = 1'b0; id_rs = 0; id_rt = 0; ex_rd = 0; id_uses_rt = 0; ex_memread = 0;
    branch_taken = 0; imem_stall = 0; dmem_stall = 0;
  endtask

  task automatic do_reset();
    idle(); rst = 1'b1;
    mid(); chk_out("reset_outputs", 5'b00110);
    nxt(); rst = 1'b0;
    chk("reset_stall_cnt", int'(stall_cnt), 0);
    chk("reset_redir_cnt", int'(redirect_cnt), 0);
  endtask

  typedef struct {
    logic       memread;
    logic [4:0] rd, rs, rt;
    logic       uses_rt, br, imem, dmem;
    logic [4:0] exp;
  } vec_t;

  vec_t vt[12];

  initial begin
    vt[0]  = '{1'b0, 5'd0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'b11000};
    vt[1]  = '{1'b1, 5'd5, 5'd5,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'b00010};
    vt[2]  = '{1'b1, 5'd0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'b11000};
    vt[3]  = '{1'b1, 5'd7, 5'd1,  5'd7,  1'b0, 1'b0, 1'b0, 1'b0, 5'b11000};
    vt[4]  = '{1'b1, 5'd7, 5'd1,  5'd7,  1'b1, 1'b0, 1'b0, 1'b0, 5'b00010};
    vt[5]  = '{1'b0, 5'd5, 5'd5,  5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 5'b11000};
    vt[6]  = '{1'b1, 5'd5, 5'd5,  5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 5'b00010};
    vt[7]  = '{1'b0, 5'd0, 5'd0,  5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 5'b10100};
    vt[8]  = '{1'b1, 5'd3, 5'd3,  5'd0,  1'b0, 1'b1, 1'b1, 1'b0, 5'b00010};
    vt[9]  = '{1'b0, 5'd0, 5'd0,  5'd0,  1'b0, 1'b1, 1'b1, 1'b1, 5'b00001};
    vt[10] = '{1'b1, 5'd4, 5'd4,  5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 5'b00001};
    vt[11] = '{1'b1, 5'd9, 5'd8,  5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 5'b11000};

    idle(); rst = 1'b1;
    nxt();
    sb_en = 1'b1;
    do_reset();

    // Single-cycle vectors, all of which leave the tracker in RUN.
    for (int i = 0; i < 12; i++) begin
      idle();
      ex_memread = vt[i].memread; ex_rd = vt[i].rd; id_rs = vt[i].rs; id_rt = vt[i].rt;
      id_uses_rt = vt[i].uses_rt; branch_taken = vt[i].br;
      imem_stall = vt[i].imem; dmem_stall = vt[i].dmem;
      mid(); chk_out($sformatf("vec%0d", i), vt[i].exp);
      nxt();
    end

    // Load-use: exactly one stall cycle.
    do_reset();
    ex_memread = 1; ex_rd = 5; id_rs = 5;
    mid(); chk_out("lu_stall", 5'b00010);
    nxt(); idle();
    mid(); chk_out("lu_after", 5'b11000);
    chk("lu_stall_cnt", int'(stall_cnt), 1);
    nxt();

    // Load-use beats branch; branch re-resolves next cycle.
    do_reset();
    ex_memread = 1; ex_rd = 5; id_rs = 5; branch_taken = 1;
    mid(); chk_out("lu_vs_br", 5'b00010);
    nxt(); chk("lu_vs_br_redir", int'(redirect_cnt), 0);
    ex_memread = 0;
    mid(); chk_out("br_retry", 5'b10100);
    nxt(); idle();
    chk("br_retry_redir", int'(redirect_cnt), 1);

    // Imem stall 3 cycles, no branch.
    do_reset();
    imem_stall = 1;
    for (int i = 0; i < 3; i++) begin
      mid(); chk_out($sformatf("istall_c%0d", i), 5'b00100);
      nxt();
    end
    imem_stall = 0;
    mid(); chk_out("istall_accept", 5'b11000);
    chk("istall_cnt", int'(stall_cnt), 3);
    nxt();

    // Branch at imem stall entry: the returning fetch is killed.
    do_reset();
    imem_stall = 1; branch_taken = 1;
    mid(); chk_out("kill_entry", 5'b10100);
    nxt(); branch_taken = 0;
    mid(); chk_out("kill_wait", 5'b00100);
    nxt(); imem_stall = 0;
    mid(); chk_out("kill_release", 5'b00100);
    nxt();
    mid(); chk_out("kill_target", 5'b11000);
    chk("kill_redir", int'(redirect_cnt), 1);
    nxt();

    // Dmem freeze inside IWAIT_KILL, then reset abandons the kill.
    do_reset();
    imem_stall = 1; branch_taken = 1;
    nxt(); branch_taken = 0; imem_stall = 0; dmem_stall = 1;
    for (int i = 0; i < 4; i++) begin
      mid(); chk_out($sformatf("freeze_c%0d", i), 5'b00001);
      nxt();
    end
    chk("freeze_stall_cnt", int'(stall_cnt), 4);
    chk("freeze_redir_cnt", int'(redirect_cnt), 1);
    do_reset();
    mid(); chk_out("post_reset_no_kill", 5'b11000);
    nxt();

    // Randomized run; counters saturate at the narrow width.
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 99) == 0);
      dmem_stall   = ($urandom_range(0, 5) == 0);
      imem_stall   = ($urandom_range(0, 2) == 0);
      branch_taken = ($urandom_range(0, 3) == 0);
      ex_memread   = ($urandom_range(0, 2) == 0);
      id_uses_rt   = $urandom_range(0, 1);
      ex_rd        = 5'($urandom_range(0, 3));
      id_rs        = 5'($urandom_range(0, 3));
      id_rt        = 5'($urandom_range(0, 3));
      nxt();
    end

    // Push both counters to saturation deterministically.
    do_reset();
    branch_taken = 1;
    for (int i = 0; i < CNT_MAX + 3; i++) nxt();
    chk("redir_saturate", int'(redirect_cnt), CNT_MAX);
    idle(); dmem_stall = 1;
    for (int i = 0; i < CNT_MAX + 3; i++) nxt();
    chk("stall_saturate", int'(stall_cnt), CNT_MAX);
    idle();
    mid();
    sb_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central pipeline sequencer for the 5-stage CPU; drives the IF/ID pipeline register and the PC, and issues bubbles into ID/EX.
- Detects load-use hazards and ID-resolved taken branches, and absorbs multi-cycle instruction-memory and data-memory stalls.
- Tracks wrong-path fetches that are in flight during a stall and kills them.
- Keeps saturating stall and redirect counters for performance debug.

Parameters:
CNT_W, 32, width of the performance counters

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
id_rs_i  in  5  rs field of instruction in ID
id_rt_i  in  5  rt field of instruction in ID
id_uses_rt_i  in  1  ID instruction reads rt as a source
ex_memread_i  in  1  instruction in EX is a load
ex_rd_i  in  5  destination register of instruction in EX
branch_taken_i  in  1  branch/jump in ID resolved taken this cycle
imem_stall_i  in  1  instruction fetch not complete this cycle
dmem_stall_i  in  1  data access in MEM not complete this cycle
pc_write_o  out  1  PC load enable (sequential or redirect target)
ifid_write_o  out  1  IF/ID load enable
ifid_flush_o  out  1  IF/ID loads all-zero (nop); overrides ifid_write_o
idex_flush_o  out  1  ID/EX loads bubble
pipe_hold_o  out  1  freeze ID/EX, EX/MEM, MEM/WB
stall_cnt_o  out  CNT_W  cycles with pc_write_o=0 (reset excluded)
redirect_cnt_o  out  CNT_W  taken-branch redirects accepted

Behaviour:
- One clock (clk_i). Reset is synchronous, active-high (rst_i).
- Outputs are Mealy: combinational on state and inputs.
- State register: RUN, IWAIT, IWAIT_KILL.
- Reset (rst_i=1 at a clk_i edge):
  - State goes to RUN; both counters go to 0.
  - While rst_i=1, outputs are: pc_write_o=0, ifid_write_o=0, ifid_flush_o=1, idex_flush_o=1, pipe_hold_o=0.
  - Reset mid-stall abandons any kill pending.
- Load-use hazard (lu) = ex_memread_i & (ex_rd_i!=0) & (ex_rd_i==id_rs_i | (id_uses_rt_i & ex_rd_i==id_rt_i)).
- Default for any output not listed below: 0.
- Priority 1, dmem_stall_i=1 (any state):
  - pipe_hold_o=1; pc_write_o, ifid_write_o and both flushes are 0.
  - State and counters except stall_cnt_o are held.
  - All other inputs are ignored.
- Priority 2, RUN with lu=1:
  - pc_write_o=0, ifid_write_o=0, idex_flush_o=1; state stays RUN.
  - branch_taken_i and imem_stall_i are ignored this cycle. Branch operands are not ready; the branch re-resolves next cycle.
- Priority 3, RUN with imem_stall_i=1:
  - ifid_flush_o=1; pc_write_o=branch_taken_i.
  - Next state is IWAIT_KILL if branch_taken_i, else IWAIT.
  - The instruction memory latches its address at request start, so a PC redirect during the stall does not disturb the in-flight fetch.
  - redirect_cnt_o increments if branch_taken_i.
- Priority 4, RUN with branch_taken_i=1: pc_write_o=1, ifid_flush_o=1; redirect_cnt_o increments.
- Otherwise in RUN: pc_write_o=1, ifid_write_o=1.
- IWAIT:
  - imem_stall_i=1: ifid_flush_o=1, pc_write_o=0.
  - imem_stall_i=0: pc_write_o=1, ifid_write_o=1; go to RUN.
- IWAIT_KILL:
  - imem_stall_i=1: ifid_flush_o=1, pc_write_o=0.
  - imem_stall_i=0: ifid_flush_o=1, pc_write_o=0; go to RUN. The returning instruction is wrong-path and is discarded; the PC already holds the target.
- In IWAIT/IWAIT_KILL, ID holds a nop, so lu and branch_taken_i are 0 by construction. The block ignores them there.
- Counters saturate at all-ones; no wrap.
- stall_cnt_o increments on every non-reset cycle where pc_write_o=0, including dmem freeze.

Test Plan:
- Load-use: LW with ex_rd_i=5 in EX, id_rs_i=5 -> exactly 1 cycle of pc_write_o=0, ifid_write_o=0, idex_flush_o=1; next cycle normal; stall_cnt_o=1.
- Load-use beats branch: lu=1 and branch_taken_i=1 same cycle -> ifid_flush_o=0, redirect_cnt_o unchanged. Next cycle branch_taken_i=1 with lu=0 -> pc_write_o=1, ifid_flush_o=1, redirect_cnt_o=1.
- ex_rd_i=0: ex_memread_i=1, ex_rd_i=0, id_rs_i=0 -> no stall. id_uses_rt_i=0 with rt match -> no stall.
- Imem stall 3 cycles, no branch -> RUN, IWAIT, IWAIT; ifid_flush_o=1 for 3 cycles; the 4th cycle accepts the instruction with ifid_write_o=1; stall_cnt_o=3.
- Branch at imem stall entry, stall 2 cycles -> pc_write_o=1 at entry, then IWAIT_KILL. The release cycle has ifid_flush_o=1 and pc_write_o=0. The following cycle fetches the target; redirect_cnt_o=1.
- dmem_stall_i=1 for 4 cycles during IWAIT_KILL, then rst_i pulse -> pipe_hold_o=1 and state held throughout the freeze. Reset returns to RUN with counters 0, and no kill is applied afterwards.
